// File: rtl/alu_exec_stage.sv
// Registered execute stage: single-cycle ALU ops plus an iterative 32-cycle shift-add multiplier.
// Results are held in an output register until downstream accepts them.
module alu_exec_stage #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_carry,
  output logic        out_ovf,
  output logic        out_illegal
);

  localparam logic [3:0] FnAdd = 4'd0;
  localparam logic [3:0] FnSub = 4'd1;
  localparam logic [3:0] FnAnd = 4'd2;
  localparam logic [3:0] FnOr  = 4'd3;
  localparam logic [3:0] FnXor = 4'd4;
  localparam logic [3:0] FnNot = 4'd5;
  localparam logic [3:0] FnSll = 4'd6;
  localparam logic [3:0] FnSra = 4'd7;
  localparam logic [3:0] FnSrl = 4'd8;
  localparam logic [3:0] FnMul = 4'd9;

  typedef enum logic [1:0] {StIdle, StBusy, StFull} state_e;

  state_e      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [5:0]  cnt;

  logic        accept;
  logic        is_mul;
  logic        is_sub;
  logic        shift_big;
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic [31:0] acc_next;
  logic [31:0] res;
  logic        res_carry;
  logic        res_ovf;
  logic        res_illegal;

  assign in_ready  = !rst && (state != StBusy) && ((state == StIdle) || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == StFull);
  assign is_mul    = MUL_EN && (in_func == FnMul);
  assign is_sub    = (in_func == FnSub);
  // Any amount >= 32 saturates the shifters
  assign shift_big = |in_b[31:5];
  assign b_eff     = is_sub ? ~in_b : in_b;
  assign sum       = {1'b0, in_a} + {1'b0, b_eff} + {32'd0, is_sub};
  assign acc_next  = acc + (mplier[0] ? mcand : 32'd0);

  always_comb begin
    res         = '0;
    res_carry   = 1'b0;
    res_ovf     = 1'b0;
    res_illegal = 1'b0;
    case (in_func)
      FnAdd, FnSub: begin
        res       = sum[31:0];
        res_carry = sum[32];
        res_ovf   = (in_a[31] == b_eff[31]) && (sum[31] != in_a[31]);
      end
      FnAnd: res = in_a & in_b;
      FnOr:  res = in_a | in_b;
      FnXor: res = in_a ^ in_b;
      FnNot: res = ~in_a;
      FnSll: res = shift_big ? 32'd0 : (in_a << in_b[4:0]);
      FnSrl: res = shift_big ? 32'd0 : (in_a >> in_b[4:0]);
      FnSra: res = shift_big ? {32{in_a[31]}} : 32'($signed(in_a) >>> in_b[4:0]);
      FnMul: res_illegal = !MUL_EN;
      default: res_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_carry   <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        StBusy: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state       <= StFull;
            out_result  <= acc_next;
            out_zero    <= (acc_next == 32'd0);
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (is_mul) begin
              state  <= StBusy;
              mcand  <= in_a;
              mplier <= in_b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              state       <= StFull;
              out_result  <= res;
              out_zero    <= (res == 32'd0);
              out_carry   <= res_carry;
              out_ovf     <= res_ovf;
              out_illegal <= res_illegal;
            end
          end else if (state == StFull && out_ready) begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed corner cases plus random ops against
// an arithmetic reference model; a second instance covers the MUL-disabled build.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_ovf;
  logic        out_illegal;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_result2;
  logic        out_zero2;
  logic        out_carry2;
  logic        out_ovf2;
  logic        out_illegal2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_illegal(out_illegal)
  );

  alu_exec_stage #(.MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_func(in_func),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(1'b1),
    .out_result(out_result2), .out_zero(out_zero2), .out_carry(out_carry2), .out_ovf(out_ovf2),
    .out_illegal(out_illegal2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model computed from the operation definitions with wide arithmetic.
  task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit mul_en, output logic [31:0] r, output logic c,
                       output logic v, output logic ill);
    longint s;
    logic [63:0] w;
    r = 0; c = 0; v = 0; ill = 0;
    case (f)
      4'd0: begin
        w = {32'd0, a} + {32'd0, b};
        r = w[31:0]; c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = (b >= 32) ? 32'd0 : a << b;
      4'd7: r = (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
      4'd8: r = (b >= 32) ? 32'd0 : a >> b;
      4'd9: begin
        if (mul_en) begin
          w = {32'd0, a} * {32'd0, b};
          r = w[31:0];
        end else ill = 1;
      end
      default: ill = 1;
    endcase
  endtask

  // Issue one op with out_ready=1 and check it against the model; leaves out_ready=1.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] er;
    logic ec, ev, ei;
    int n;
    model(f, a, b, 1'b1, er, ec, ev, ei);
    @(negedge clk);
    in_valid = 1; in_func = f; in_a = a; in_b = b; out_ready = 1;
    #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 0;
    in_a = $urandom; in_b = $urandom; in_func = 4'($urandom);
    if (f == 4'd9) begin
      check({tag, ".busy_valid"}, 32'(out_valid), 32'd0);
      n = 0;
      while (!out_valid && n < 40) begin
        check({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 n++;
      end
      check({tag, ".latency"}, n, 32);
    end
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, out_result, er);
    check({tag, ".zero"}, 32'(out_zero), 32'(er == 0));
    check({tag, ".carry"}, 32'(out_carry), 32'(ec));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(ev));
    check({tag, ".illegal"}, 32'(out_illegal), 32'(ei));
  endtask

  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h20};

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
  endfunction

  initial begin
    logic [31:0] hold;
    logic [3:0]  f;
    logic [31:0] b;
    rst = 1; in_valid = 0; in_valid2 = 0; out_ready = 0;
    in_func = 0; in_a = 0; in_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.flags", {out_zero, out_carry, out_ovf, out_illegal}, 32'd0);
    check("rst.result", out_result, 32'd0);
    @(negedge clk) rst = 0;
    #1 check("rel.in_ready", 32'(in_ready), 32'd1);

    // SRA / SRL saturation boundaries
    run_op("sra4", 4'd7, 32'h80000010, 32'd4);
    check("sra4.lit", out_result, 32'hF8000001);
    run_op("sra31", 4'd7, 32'h80000010, 32'd31);
    run_op("sra32", 4'd7, 32'h80000010, 32'd32);
    run_op("sra_hi", 4'd7, 32'h80000010, 32'h80000001);
    check("sra_hi.lit", out_result, 32'hFFFFFFFF);
    run_op("sra_pos", 4'd7, 32'h40000000, 32'h100);
    run_op("srl33", 4'd8, 32'h80000000, 32'd33);
    run_op("sll33", 4'd6, 32'h00000001, 32'd33);

    // ADD/SUB flags
    run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'd1);
    check("add_ovf.lit", 32'(out_ovf), 32'd1);
    run_op("add_cy", 4'd0, 32'hFFFFFFFF, 32'd1);
    run_op("sub_eq", 4'd1, 32'd5, 32'd5);
    check("sub_eq.lit", {out_zero, out_carry}, 32'd3);
    run_op("sub_neg", 4'd1, 32'd3, 32'd5);
    check("sub_neg.lit", out_result, 32'hFFFFFFFE);

    // MUL latency and value
    run_op("mul5", 4'd9, 32'h00010003, 32'd5);
    check("mul5.lit", out_result, 32'h0005000F);
    run_op("mul_m1", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Backpressure then back-to-back accept
    run_op("xor", 4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    out_ready = 0;
    hold = out_result;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.result", out_result, hold);
      check("bp.flags", {out_zero, out_carry, out_ovf, out_illegal}, 32'd0);
      check("bp.in_ready", 32'(in_ready), 32'd0);
    end
    run_op("and_b2b", 4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F);
    run_op("illegal", 4'd12, 32'h1234, 32'h5678);

    // Reset during a MUL discards it
    @(negedge clk);
    in_valid = 1; in_func = 4'd9; in_a = 32'd7; in_b = 32'd9; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    #1 check("rstmul.in_ready", 32'(in_ready), 32'd0);
    check("rstmul.valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1 check("rstmul.rel_ready", 32'(in_ready), 32'd1);
    check("rstmul.rel_valid", 32'(out_valid), 32'd0);
    repeat (35) @(posedge clk);
    #1 check("rstmul.no_emit", 32'(out_valid), 32'd0);
    run_op("add23", 4'd0, 32'd2, 32'd3);
    check("add23.lit", out_result, 32'd5);

    // MUL disabled build: func 9 is illegal with one-cycle latency
    @(negedge clk);
    in_valid2 = 1; in_func = 4'd9; in_a = 32'd6; in_b = 32'd7;
    @(posedge clk);
    #1 in_valid2 = 0;
    check("nomul.valid", 32'(out_valid2), 32'd1);
    check("nomul.result", out_result2, 32'd0);
    check("nomul.flags", {out_zero2, out_carry2, out_ovf2, out_illegal2}, 32'b1001);

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      f = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : pick();
      run_op($sformatf("rnd%0d", i), f, pick(), b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
